compute_arbiter: RTL
====================

# compute_arbiter

Shares one multi-cycle compute engine among `N_REQ` requesters. The arbiter picks one requester round-robin and steers its operands through `eng_sel`. It then sequences the engine's reset/start/done handshake and returns a one-cycle `ack` to the winner. It sits between the requesting units and the engine's `inner_rst`/`inner_start`/`done` pins, replacing a single-owner start/done controller.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `SEL_W`, default `$clog2(N_REQ)`: width of `eng_sel`; derived, never overridden.
- `TIMEOUT`, default 1023: maximum number of BUSY cycles before the engine is aborted. Used only when `COMPUTE_ARB_WATCHDOG_EN` is defined.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, `N_REQ`: per-requester job request; level, held high until `ack`.
- `ack`, out, `N_REQ`: one-hot, one-cycle job-complete pulse to the granted requester.
- `busy`, out, 1: high in every state except IDLE.
- `eng_sel`, out, `SEL_W`: index of the current owner; drives the operand/result muxes.
- `eng_rst`, out, 1: engine reset (feeds `inner_rst`).
- `eng_start`, out, 1: engine start pulse (feeds `inner_start`).
- `eng_done`, in, 1: engine completion, asserted for at least one cycle.
- `timeout_err`, out, 1: one-cycle pulse when the watchdog aborts a job.

## Operation
- Moore FSM with states IDLE, LOAD, START, BUSY, ACK. All outputs come from registered state plus the `sel` and `last` registers.
- **IDLE**
  - Outputs: `eng_rst`=1, `eng_start`=0, `busy`=0.
  - If any `req` bit is high, compute the winner, latch it into `sel`, and go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - Outputs: `eng_rst`=1, `busy`=1, `eng_sel`=`sel`. This holds the engine in reset for one cycle while the muxes settle.
  - Always go to START.
- **START**
  - Outputs: `eng_rst`=0, `eng_start`=1 for exactly one cycle.
  - Always go to BUSY.
  - `eng_done` is ignored in this state.
- **BUSY**
  - Outputs: `eng_rst`=0, `eng_start`=0.
  - On `eng_done`=1, go to ACK.
- **ACK**
  - Outputs: `ack[sel]`=1, `eng_rst`=0.
  - Set `last` to `sel`, then go to IDLE.
- **Round-robin rule:** search starts at `(last+1) mod N_REQ` and wraps around. The first set `req` bit wins.
- **Requester rule:** drop `req` on the edge following `ack`, so `req` is already low in the next IDLE cycle. A requester that keeps `req` high is re-queued as a new job.
- **Request changes during a job:** `req` changes outside IDLE are ignored. A requester that deasserts before being granted is not served.
- **Reset mid-operation:** `rst` forces IDLE on the next edge from any state. `ack`, `eng_start` and `timeout_err` go low immediately. No `ack` is generated for the aborted job.

## Timing
- Reset values:
  - `state`=IDLE, `sel`=0, `last`=`N_REQ-1` (so requester 0 wins first).
  - Outputs: `ack`=0, `busy`=0, `eng_sel`=0, `eng_rst`=1, `eng_start`=0, `timeout_err`=0.
- Grant latency: `req` high in IDLE cycle t gives LOAD in t+1, `eng_start` in t+2, and BUSY from t+3.
- Completion: `eng_done` sampled high in BUSY cycle d gives `ack` in cycle d+1 and IDLE in d+2.
- Minimum job period: 5 cycles, for an engine that asserts done in its first BUSY cycle.
- `eng_sel` is stable from LOAD through ACK inclusive.

## Configuration
- `COMPUTE_ARB_WATCHDOG_EN` defined:
  - A counter of width `$clog2(TIMEOUT+1)` clears in START and increments in each BUSY cycle.
  - If the count reaches `TIMEOUT` with `eng_done`=0, go to ACK with `timeout_err`=1 and `eng_rst`=1 for that cycle. `ack[sel]` still fires.
  - If `eng_done` and the timeout occur in the same cycle, `eng_done` wins and no error is raised.
- Not defined: no counter is built, `timeout_err` is tied to 0, and BUSY waits indefinitely.

## Structure
- Package `compute_arb_pkg` holds:
  - the state enum with fixed 3-bit encodings (IDLE=0, LOAD=1, START=2, BUSY=3, ACK=4);
  - the default `TIMEOUT` constant.
- Sub-module `rr_arbiter` contains the `last` pointer register, the rotate/priority-pick logic and the `update` strobe. The top-level FSM contains everything else.

## Test plan
- **Single request, 3-cycle engine:** `N_REQ`=4, `req`=0001, engine asserts done 3 cycles after start. Expect `eng_sel`=0, `eng_start` at t+2, `ack`=0001 exactly once, `eng_rst`=1 back in IDLE.
- **Round-robin:** `req`=1111 held, each requester drops on its `ack`. Expect grant order 0,1,2,3. A second batch with `req`=1111 gives order 0,1,2,3 again.
- **Wrap-around:** `last`=2 after a job for requester 2, then `req`=0011. Expect requester 0 wins, then requester 1.
- **Reset mid-job:** assert `rst` while in BUSY for requester 1. Expect the next cycle shows IDLE, `busy`=0, `eng_rst`=1, no `ack`, and `last`=3.
- **Watchdog (macro on, `TIMEOUT`=8):** `eng_done` never asserted. Expect `timeout_err`=1 and `ack[sel]`=1 in the same cycle, 8 BUSY cycles after START.
- **Watchdog tie:** `eng_done` asserted exactly at count 8. Expect `timeout_err`=0.

Source files
------------

// File: rtl/compute_arb_pkg.sv
// compute_arb_pkg: FSM state encoding and default watchdog limit for compute_arbiter.
package compute_arb_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    ACK   = 3'd4
  } state_t;
  localparam int DEF_TIMEOUT = 1023;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick starting after the last served requester; update stores the new last.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             update,
  input  logic [SEL_W-1:0] upd_sel,
  output logic [SEL_W-1:0] pick,
  output logic             found
);
  logic [SEL_W-1:0] last_q, last_d, cand;
  always_comb begin
    last_d = update ? upd_sel : last_q;
    pick = '0;
    found = 1'b0;
    cand = '0;
    // walk from farthest to nearest so the nearest set request is written last
    for (int i = N_REQ; i >= 1; i--) begin
      cand = SEL_W'((int'(last_q) + i) % N_REQ);
      if (req[cand]) begin
        pick = cand;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    last_q <= rst ? SEL_W'(N_REQ - 1) : last_d;
  end
endmodule

// File: rtl/compute_arbiter.sv
// compute_arbiter: shares one start/done compute engine among N_REQ requesters round-robin.
// Defining COMPUTE_ARB_WATCHDOG_EN adds a BUSY timeout that aborts the job with timeout_err.
module compute_arbiter
  import compute_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int SEL_W   = $clog2(N_REQ),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             busy,
  output logic [SEL_W-1:0] eng_sel,
  output logic             eng_rst,
  output logic             eng_start,
  input  logic             eng_done,
  output logic             timeout_err
);
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, pick;
  logic found, expire, err_q;
  rr_arbiter #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_rr (
    .clk(clk),
    .rst(rst),
    .req(req),
    .update(state_q == ACK),
    .upd_sel(sel_q),
    .pick(pick),
    .found(found)
  );
`ifdef COMPUTE_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_d;
  assign expire = cnt_q == CNT_W'(TIMEOUT - 1);
  always_comb begin
    cnt_d = (state_q == START) ? '0 : (state_q == BUSY) ? cnt_q + 1'b1 : cnt_q;
    err_d = (state_q == BUSY) && !eng_done && expire;
  end
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
    err_q <= rst ? 1'b0 : err_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire = 1'b0;
  assign err_q = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    case (state_q)
      IDLE: begin
        state_d = found ? LOAD : IDLE;
        sel_d = found ? pick : sel_q;
      end
      LOAD:    state_d = START;
      START:   state_d = BUSY;
      BUSY:    state_d = (eng_done || expire) ? ACK : BUSY;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
    end
  end
  assign ack = (state_q == ACK) ? {{(N_REQ-1){1'b0}}, 1'b1} << sel_q : '0;
  assign busy = state_q != IDLE;
  assign eng_sel = sel_q;
  assign eng_rst = (state_q == IDLE) || (state_q == LOAD) || err_q;
  assign eng_start = state_q == START;
  assign timeout_err = err_q;
endmodule
